// File: rtl/half_predict_layer1.sv
// half_predict_layer1: binary16 dense layer l = b1 + x*W1, one input per clock.
// Option HALF_PREDICT_LAYER1_SATURATE_EN: overflow saturates to +-max finite.
module half_predict_layer1 #(
  parameter int LAYER1_NEURONS = 784,
  parameter int LAYER2_NEURONS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x  [LAYER1_NEURONS],
  input  logic [15:0] W1 [LAYER1_NEURONS][LAYER2_NEURONS],
  input  logic [15:0] b1 [LAYER2_NEURONS],
  output logic        done,
  output logic [15:0] l  [LAYER2_NEURONS]
);

  localparam int IW = (LAYER1_NEURONS > 1) ? $clog2(LAYER1_NEURONS) : 1;
  localparam logic [IW-1:0] LAST = IW'(LAYER1_NEURONS - 1);
  localparam logic [15:0] QNAN = 16'h7E00;

  typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

  function automatic logic [15:0] ovf(input logic s);
`ifdef HALF_PREDICT_LAYER1_SATURATE_EN
    ovf = {s, 15'h7BFF};
`else
    ovf = {s, 15'h7C00};
`endif
  endfunction

  function automatic logic [15:0] fp_mul(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic        s, za, zb, ia, ib, na, nb, g, st;
    logic [21:0] p;
    logic [11:0] m;
    logic signed [7:0] e;
    logic [15:0] r;
    s  = a[15] ^ b[15];
    za = (a[14:10] == 5'h00);
    zb = (b[14:10] == 5'h00);
    ia = (a[14:0] == 15'h7C00);
    ib = (b[14:0] == 15'h7C00);
    na = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    nb = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    p  = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    if (p[21]) begin
      m  = {1'b0, p[21:11]};
      g  = p[10];
      st = |p[9:0];
      e  = 8'sd1;
    end else begin
      m  = {1'b0, p[20:10]};
      g  = p[9];
      st = |p[8:0];
      e  = 8'sd0;
    end
    e = e + $signed({3'b0, a[14:10]})
          + $signed({3'b0, b[14:10]}) - 8'sd15;
    if (g && (st || m[0])) m = m + 12'd1;
    if (m[11]) begin
      m = m >> 1;
      e = e + 8'sd1;
    end
    if (na || nb) r = QNAN;
    else if (ia || ib) r = (za || zb) ? QNAN : {s, 15'h7C00};
    else if (za || zb) r = {s, 15'h0};
    else if (e >= 8'sd31) r = ovf(s);
    else if (e <= 8'sd0) r = {s, 15'h0};
    else r = {s, e[4:0], m[9:0]};
    return r;
  endfunction

  function automatic logic [15:0] fp_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic        s, za, zb, ia, ib, na, nb, sw, cz, hit, g, st;
    logic [4:0]  eg, es, d;
    logic [10:0] mg, ms;
    logic [24:0] w;
    logic [13:0] bg, sm, v;
    logic [14:0] sum;
    logic [3:0]  lz;
    logic [11:0] m;
    logic signed [7:0] e;
    logic [15:0] r;
    za = (a[14:10] == 5'h00);
    zb = (b[14:10] == 5'h00);
    ia = (a[14:0] == 15'h7C00);
    ib = (b[14:0] == 15'h7C00);
    na = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    nb = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    sw = (b[14:0] > a[14:0]);
    s  = sw ? b[15] : a[15];
    eg = sw ? b[14:10] : a[14:10];
    es = sw ? a[14:10] : b[14:10];
    mg = {1'b1, sw ? b[9:0] : a[9:0]};
    ms = {1'b1, sw ? a[9:0] : b[9:0]};
    d  = eg - es;
    // Cap keeps the hidden bit inside the sticky field
    w  = {ms, 14'b0} >> ((d > 5'd24) ? 5'd24 : d);
    sm = {w[24:12], |w[11:0]};
    bg = {mg, 3'b000};
    sum = {1'b0, bg} + {1'b0, sm};
    cz  = (a[15] != b[15]) && (bg == sm);
    lz  = '0;
    hit = 1'b0;
    e   = $signed({3'b0, eg});
    if (a[15] == b[15]) begin
      if (sum[14]) begin
        v = {sum[14:2], |sum[1:0]};
        e = e + 8'sd1;
      end else begin
        v = sum[13:0];
      end
    end else begin
      v = bg - sm;
      for (int i = 13; i >= 0; i--) begin
        if (v[i]) hit = 1'b1;
        else if (!hit) lz = lz + 4'd1;
      end
      v = v << lz;
      e = e - $signed({4'b0, lz});
    end
    m  = {1'b0, v[13:3]};
    g  = v[2];
    st = |v[1:0];
    if (g && (st || m[0])) m = m + 12'd1;
    if (m[11]) begin
      m = m >> 1;
      e = e + 8'sd1;
    end
    if (na || nb || (ia && ib && (a[15] != b[15]))) r = QNAN;
    else if (ia) r = {a[15], 15'h7C00};
    else if (ib) r = {b[15], 15'h7C00};
    else if (za && zb) r = {a[15] & b[15], 15'h0};
    else if (za) r = b;
    else if (zb) r = a;
    else if (cz) r = 16'h0000;
    else if (e >= 8'sd31) r = ovf(s);
    else if (e <= 8'sd0) r = {s, 15'h0};
    else r = {s, e[4:0], m[9:0]};
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;
  logic [15:0]     acc_q  [LAYER2_NEURONS];
  logic [15:0]     acc_d  [LAYER2_NEURONS];
  logic [15:0]     l_q    [LAYER2_NEURONS];
  logic [15:0]     l_d    [LAYER2_NEURONS];
  logic [15:0]     lane   [LAYER2_NEURONS];
  logic [15:0]     x_cur;

  assign x_cur = x[idx_q];

  always_comb begin
    for (int j = 0; j < LAYER2_NEURONS; j++) begin
      lane[j] = fp_add(acc_q[j], fp_mul(x_cur, W1[idx_q][j]));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    l_d     = l_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = b1;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = lane;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) state_d = FIN;
      end
      FIN: begin
        l_d     = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int j = 0; j < LAYER2_NEURONS; j++) begin
        acc_q[j] <= '0;
        l_q[j]   <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      l_q     <= l_d;
    end
  end

  assign done = done_q;
  assign l    = l_q;

endmodule

// File: tb/tb_half_predict_layer1.sv
// tb_half_predict_layer1: directed vectors for the binary16 dense layer.
// Table of whole-run vectors plus reset / restart / ignored-start sequences.
module tb_half_predict_layer1;

  localparam int N1 = 784;
  localparam int N2 = 50;
  localparam int LAT = 785;
`ifdef HALF_PREDICT_LAYER1_SATURATE_EN
  localparam logic [15:0] OVF = 16'h7BFF;
`else
  localparam logic [15:0] OVF = 16'h7C00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x  [N1];
  logic [15:0] W1 [N1][N2];
  logic [15:0] b1 [N2];
  logic        done;
  logic [15:0] l  [N2];

  int checks = 0;
  int errors = 0;

  half_predict_layer1 #(
    .LAYER1_NEURONS(N1),
    .LAYER2_NEURONS(N2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .W1   (W1),
    .b1   (b1),
    .done (done),
    .l    (l)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] xf, wf, bf;
    int          si, sj;
    logic [15:0] sx, sw;
    int          oj;
    logic [15:0] eo, er;
    bit          rest;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < N1; i++) begin
      x[i] = v.xf;
      for (int j = 0; j < N2; j++) W1[i][j] = v.wf;
    end
    for (int j = 0; j < N2; j++) b1[j] = v.bf;
    if (v.si >= 0) begin
      x[v.si] = v.sx;
      if (v.sj >= 0) W1[v.si][v.sj] = v.sw;
    end
  endtask

  // Returns #1 after the edge where done is first seen (or budget expiry)
  task automatic run_start(output int n, output bit got);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
  endtask

  function automatic int nonzero_l();
    int c = 0;
    for (int j = 0; j < N2; j++) if (l[j] !== 16'h0000) c++;
    return c;
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    bit got;
    logic [15:0] keep;
    load(v);
    run_start(n, got);
    chk({v.name, " latency"}, got ? n : 0, LAT);
    for (int j = 0; j < N2; j++) begin
      if (j == v.oj || v.rest)
        chk($sformatf("%s l[%0d]", v.name, j), l[j],
            (j == v.oj) ? v.eo : v.er);
    end
    keep = l[v.oj];
    @(posedge clk);
    #1;
    chk({v.name, " done_clears"}, done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({v.name, " l_holds"}, l[v.oj], keep);
  endtask

  initial begin : main
    int n, nd, first;
    bit got;

    vt[0]  = '{"zero_x",   16'h0000, 16'h3C00, 16'h3C00, -1, -1,
               16'h0000, 16'h0000, 0, 16'h3C00, 16'h3C00, 1'b1};
    vt[1]  = '{"exact49",  16'h3C00, 16'h2C00, 16'h0000, -1, -1,
               16'h0000, 16'h0000, 0, 16'h5220, 16'h5220, 1'b1};
    vt[2]  = '{"cancel",   16'h0000, 16'h3C00, 16'hBC00, 0, -1,
               16'h3C00, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1};
    vt[3]  = '{"overflow", 16'h0000, 16'h0000, 16'h0000, 0, 0,
               16'h7BFF, 16'h4000, 0, OVF, 16'h0000, 1'b1};
    vt[4]  = '{"nan_x",    16'h0000, 16'h0000, 16'h0000, 3, 5,
               16'h7E00, 16'h3C00, 5, 16'h7E00, 16'h0000, 1'b0};
    vt[5]  = '{"nan_w",    16'h0000, 16'h0000, 16'h0000, 3, 5,
               16'h3C00, 16'h7E00, 5, 16'h7E00, 16'h0000, 1'b1};
    vt[6]  = '{"mul_tie",  16'h0000, 16'h3C01, 16'h0000, 0, -1,
               16'h3E00, 16'h0000, 0, 16'h3E02, 16'h3E02, 1'b1};
    vt[7]  = '{"add_even", 16'h0000, 16'h3C00, 16'h6800, 0, -1,
               16'h3C00, 16'h0000, 0, 16'h6800, 16'h6800, 1'b1};
    vt[8]  = '{"add_up",   16'h0000, 16'h3C00, 16'h6800, 0, -1,
               16'h4200, 16'h0000, 0, 16'h6802, 16'h6802, 1'b1};
    vt[9]  = '{"signs",    16'h0000, 16'h4200, 16'h4000, 0, -1,
               16'hC000, 16'h0000, 0, 16'hC400, 16'hC400, 1'b1};
    vt[10] = '{"subn_in",  16'h0000, 16'h7BFF, 16'h3C00, 0, -1,
               16'h0001, 16'h0000, 0, 16'h3C00, 16'h3C00, 1'b1};
    vt[11] = '{"flush",    16'h0000, 16'h3800, 16'h0000, 0, -1,
               16'h0400, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    load(vt[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", done, 0);
    chk("reset l", nonzero_l(), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle done", done, 0);

    for (int t = 0; t < 12; t++) run_vec(vt[t]);

    // Reset in the middle of a run
    run_vec(vt[0]);
    load(vt[1]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst l_cleared", nonzero_l(), 0);
    nd = 0;
    for (int c = 0; c < 900; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("midrst no_done", nd, 0);
    chk("midrst l_zero", nonzero_l(), 0);
    run_vec(vt[1]);

    // Second start mid-run is ignored
    load(vt[0]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0;
    first = 0;
    for (int c = 1; c <= 1700; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        nd++;
        if (first == 0) first = c;
      end
      if (c == 300) start = 1'b1;
    end
    chk("dblstart count", nd, 1);
    chk("dblstart latency", first, LAT);
    chk("dblstart l", l[7], 16'h3C00);

    // Start in the same cycle as done
    load(vt[1]);
    run_start(n, got);
    chk("b2b first", got ? n : 0, LAT);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
    end
    chk("b2b second", got ? n : 0, LAT);
    chk("b2b l", l[N2-1], 16'h5220);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
